mem_dma_engine: RTL

Memory-side initiator that drives the single-port `data_memory` (8-bit word address, 64-bit words, write on clock edge, combinational read) to run block operations without processor involvement. It accepts one command at a time (block copy, block fill or block checksum) over a start/busy/done handshake and sequences the memory strobes word by word. It sits between the control path and the memory port; arbitration with other initiators is outside this block.

---
 rtl/mem_dma_engine_if.sv | 34 +++
 rtl/mem_dma_engine.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_dma_engine_if.sv
// Control and memory-port bundle for mem_dma_engine.
// master = engine side, slave = controller/memory side.
interface mem_dma_engine_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
);
   logic              start;
   logic [1:0]        op;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [ADDR_W:0]   len;
   logic [DATA_W-1:0] fill_value;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] sum_out;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_write_en;
   logic              mem_read_en;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  start, op, src_addr, dst_addr, len, fill_value, mem_rdata,
      output busy, done, err, sum_out,
      output mem_address, mem_wdata, mem_write_en, mem_read_en
   );

   modport slave (
      output start, op, src_addr, dst_addr, len, fill_value, mem_rdata,
      input  busy, done, err, sum_out,
      input  mem_address, mem_wdata, mem_write_en, mem_read_en
   );
endinterface

// File: rtl/mem_dma_engine.sv
// Block copy / fill / checksum initiator for a single-port data memory.
// One command at a time; strobes decode straight from state.
module mem_dma_engine #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_dma_engine_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_COPY = 2'b00;
   localparam logic [1:0] OP_FILL = 2'b01;
   localparam logic [1:0] OP_ILL  = 2'b11;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_idx;
   logic [DATA_W-1:0] r_fill;
   logic [DATA_W-1:0] r_buf;
   logic              r_err;
   logic [DATA_W-1:0] r_sum;

   logic              w_last;
   logic              w_busy;
   logic              w_done;
   logic              w_rd;
   logic              w_wr;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   assign w_last = (r_idx + (ADDR_W+1)'(1)) == r_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_src   <= '0;
         r_dst   <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_fill  <= '0;
         r_buf   <= '0;
         r_err   <= 1'b0;
         r_sum   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_op   <= bus.op;
                  r_src  <= bus.src_addr;
                  r_dst  <= bus.dst_addr;
                  r_len  <= bus.len;
                  r_fill <= bus.fill_value;
                  r_idx  <= '0;
                  r_sum  <= '0;
                  r_err  <= (bus.op == OP_ILL);
               end
            end
            S_READ: begin
               if (r_op == OP_COPY) begin
                  r_buf <= bus.mem_rdata;
               end else begin
                  r_sum <= r_sum + bus.mem_rdata;
                  r_idx <= r_idx + (ADDR_W+1)'(1);
               end
            end
            S_WRITE: r_idx <= r_idx + (ADDR_W+1)'(1);
            default: ;
         endcase
      end
   end

   // Copy alternates READ/WRITE per word; idx only advances on the write.
   always_comb begin
      w_next  = r_state;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.len == '0 || bus.op == OP_ILL)
                  w_next = S_DONE;
               else if (bus.op == OP_FILL)
                  w_next = S_WRITE;
               else
                  w_next = S_READ;
            end
         end
         S_READ: begin
            w_busy = 1'b1;
            w_rd   = 1'b1;
            w_addr = r_src + r_idx[ADDR_W-1:0];
            if (r_op == OP_COPY)
               w_next = S_WRITE;
            else if (w_last)
               w_next = S_DONE;
         end
         S_WRITE: begin
            w_busy  = 1'b1;
            w_wr    = 1'b1;
            w_addr  = r_dst + r_idx[ADDR_W-1:0];
            w_wdata = (r_op == OP_COPY) ? r_buf : r_fill;
            if (w_last)
               w_next = S_DONE;
            else if (r_op == OP_COPY)
               w_next = S_READ;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.busy         = w_busy;
   assign bus.done         = w_done;
   assign bus.err          = r_err;
   assign bus.sum_out      = r_sum;
   assign bus.mem_address  = w_addr;
   assign bus.mem_wdata    = w_wdata;
   assign bus.mem_read_en  = w_rd;
   assign bus.mem_write_en = w_wr;
endmodule
